trig_sched: RTL and testbench

TRIG_SCHED -- requirements
Module: trig_sched

---
 rtl/trig_sched.sv | 143 ++++++++++++++
 tb/tb_trig_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_sched.sv
// Trigger pulse scheduler: accepts a command, then emits (repeat+1) pulses of
// programmable width separated by programmable low time, with abort support.
module trig_sched #(
  parameter int B = 8,
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [B-1:0] cmd_wait,
  input  logic [B-1:0] cmd_delay,
  input  logic [B-1:0] cmd_width,
  input  logic [R-1:0] cmd_repeat,
  input  logic         stop,
  output logic         trigger,
  output logic [B-1:0] wait_reg,
  output logic         busy,
  output logic         done,
  output logic         aborted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2
  } state_t;

  state_t         state_q, state_nx;
  logic [B-1:0]   cnt_q, cnt_nx;
  logic [R-1:0]   rpt_q, rpt_nx;
  logic [B-1:0]   delay_q;
  logic [B-1:0]   width_m1_q;
  logic [B-1:0]   wait_q;
  logic           done_q, done_nx;
  logic           aborted_q, aborted_nx;
  logic           accept;

  // Decrement that holds at zero; also maps a zero width onto a one-cycle pulse.
  function automatic logic [B-1:0] dec_sat(input logic [B-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic logic [R-1:0] dec_sat_r(input logic [R-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign cmd_ready = (state_q == IDLE) && !stop;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_nx   = state_q;
    cnt_nx     = cnt_q;
    rpt_nx     = rpt_q;
    done_nx    = 1'b0;
    aborted_nx = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rpt_nx = cmd_repeat;
          if (cmd_delay == '0) begin
            state_nx = HIGH;
            cnt_nx   = dec_sat(cmd_width);
          end else begin
            state_nx = DELAY;
            cnt_nx   = dec_sat(cmd_delay);
          end
        end
      end
      DELAY: begin
        if (stop) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          rpt_nx     = '0;
          aborted_nx = 1'b1;
        end else if (cnt_q == '0) begin
          state_nx = HIGH;
          cnt_nx   = width_m1_q;
        end else begin
          cnt_nx = dec_sat(cnt_q);
        end
      end
      HIGH: begin
        // Abort takes priority even on the last high cycle of the last pulse.
        if (stop) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          rpt_nx     = '0;
          aborted_nx = 1'b1;
        end else if (cnt_q == '0) begin
          if (rpt_q != '0) begin
            state_nx = DELAY;
            cnt_nx   = delay_q;
            rpt_nx   = dec_sat_r(rpt_q);
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
            done_nx  = 1'b1;
          end
        end else begin
          cnt_nx = dec_sat(cnt_q);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        rpt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rpt_q      <= '0;
      delay_q    <= '0;
      width_m1_q <= '0;
      wait_q     <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      rpt_q     <= rpt_nx;
      done_q    <= done_nx;
      aborted_q <= aborted_nx;
      if (accept) begin
        delay_q    <= cmd_delay;
        width_m1_q <= dec_sat(cmd_width);
        wait_q     <= cmd_wait;
      end
    end
  end

  // Outputs decode registered state only, so reset clears trigger without a clock.
  assign trigger  = (state_q == HIGH);
  assign busy     = (state_q != IDLE);
  assign wait_reg = wait_q;
  assign done     = done_q;
  assign aborted  = aborted_q;

endmodule

// File: tb/tb_trig_sched.sv
// Directed bench for trig_sched: hand-computed pulse timelines, abort, reset
// and long-count behaviour.
module tb_trig_sched;

  localparam int B = 8;
  localparam int R = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [B-1:0] cmd_wait;
  logic [B-1:0] cmd_delay;
  logic [B-1:0] cmd_width;
  logic [R-1:0] cmd_repeat;
  logic         stop;
  logic         trigger;
  logic [B-1:0] wait_reg;
  logic         busy;
  logic         done;
  logic         aborted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trig_sched #(.B(B), .R(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wait   (cmd_wait),
    .cmd_delay  (cmd_delay),
    .cmd_width  (cmd_width),
    .cmd_repeat (cmd_repeat),
    .stop       (stop),
    .trigger    (trigger),
    .wait_reg   (wait_reg),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one edge; returns 1 ns after the accepting edge E.
  task automatic issue(input int w, input int d, input int wd, input int r);
    cmd_wait   = B'(w);
    cmd_delay  = B'(d);
    cmd_width  = B'(wd);
    cmd_repeat = R'(r);
    cmd_valid  = 1'b1;
    step();
    cmd_valid  = 1'b0;
  endtask

  // Observes a pulse train from just after E until done (bounded).
  task automatic run_train(input int max_cyc, output int pulses, output int first_rise,
                           output int last_rise, output int min_gap, output int max_gap,
                           output int hi_cyc, output int end_k);
    logic prev;
    prev       = 1'b0;
    pulses     = 0;
    first_rise = -1;
    last_rise  = -1;
    min_gap    = 1 << 30;
    max_gap    = 0;
    hi_cyc     = 0;
    end_k      = -1;
    for (int k = 0; k <= max_cyc; k++) begin
      if (trigger && !prev) begin
        if (pulses > 0) begin
          if (k - last_rise < min_gap) min_gap = k - last_rise;
          if (k - last_rise > max_gap) max_gap = k - last_rise;
        end else begin
          first_rise = k;
        end
        pulses++;
        last_rise = k;
      end
      if (trigger) hi_cyc++;
      if (done) begin
        end_k = k;
        break;
      end
      prev = trigger;
      step();
    end
  endtask

  initial begin
    int pulses, first_rise, last_rise, min_gap, max_gap, hi_cyc, end_k;
    logic exp_t;

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_wait   = '0;
    cmd_delay  = '0;
    cmd_width  = '0;
    cmd_repeat = '0;
    stop       = 1'b0;
    step();
    step();
    chk("rst_trigger", trigger, 0);
    chk("rst_wait_reg", wait_reg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", cmd_ready, 1);

    // D=3 W=2 R=1 wait=5: high E+3..4, low E+5..8, high E+9..10, done E+11
    issue(5, 3, 2, 1);
    chk("c1_wait_reg", wait_reg, 5);
    chk("c1_trig_E", trigger, 0);
    chk("c1_busy_E", busy, 1);
    chk("c1_ready_E", cmd_ready, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_t = (k == 3 || k == 4 || k == 9 || k == 10);
      chk($sformatf("c1_trig_E+%0d", k), trigger, exp_t);
      chk($sformatf("c1_done_E+%0d", k), done, (k == 11));
      if (k == 11) begin
        chk("c1_ready_done", cmd_ready, 1);
        chk("c1_busy_done", busy, 0);
      end else if (k < 11) begin
        chk($sformatf("c1_busy_E+%0d", k), busy, 1);
      end
    end
    chk("c1_wait_hold", wait_reg, 5);

    // D=0 W=0 R=0: single one-cycle pulse right after E
    issue(1, 0, 0, 0);
    chk("c2_trig_E", trigger, 1);
    chk("c2_done_E", done, 0);
    step();
    chk("c2_trig_E+1", trigger, 0);
    chk("c2_done_E+1", done, 1);
    step();
    chk("c2_done_E+2", done, 0);

    // D=2 W=4 R=3, stop during second high (E+9)
    issue(2, 2, 4, 3);
    for (int k = 1; k <= 9; k++) step();
    chk("c3_trig_2nd_high", trigger, 1);
    stop = 1'b1;
    step();
    chk("c3_trig_after_stop", trigger, 0);
    chk("c3_aborted", aborted, 1);
    chk("c3_done", done, 0);
    chk("c3_busy", busy, 0);
    chk("c3_wait_keep", wait_reg, 2);
    step();
    chk("c3_aborted_once", aborted, 0);
    chk("c3_ready_stop_idle", cmd_ready, 0);
    stop = 1'b0;
    #1;
    chk("c3_ready_released", cmd_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("c3_no_done_%0d", k), done, 0);
    end

    // Back-to-back with cmd_valid held: second accepted in the done cycle
    issue(3, 0, 1, 0);
    cmd_valid  = 1'b1;
    cmd_wait   = 8'd7;
    cmd_width  = 8'd2;
    chk("c4_trig_E1", trigger, 1);
    step();
    chk("c4_done_E1+1", done, 1);
    chk("c4_trig_gap", trigger, 0);
    chk("c4_ready_in_done", cmd_ready, 1);
    chk("c4_wait_old", wait_reg, 3);
    step();
    cmd_valid = 1'b0;
    chk("c4_wait_new", wait_reg, 7);
    chk("c4_trig_E2", trigger, 1);
    step();
    chk("c4_trig_E2+1", trigger, 1);
    step();
    chk("c4_trig_E2+2", trigger, 0);
    chk("c4_done_E2+2", done, 1);
    step();

    // Reset during DELAY with wait=9
    issue(9, 5, 2, 0);
    step();
    step();
    chk("c5_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("c5_trig", trigger, 0);
    chk("c5_wait_reg", wait_reg, 0);
    chk("c5_busy", busy, 0);
    step();
    rst = 1'b0;
    step();
    chk("c5_done", done, 0);
    chk("c5_aborted", aborted, 0);
    chk("c5_ready", cmd_ready, 1);

    // Reset during HIGH drops trigger without waiting for a clock edge
    issue(3, 0, 3, 0);
    chk("c6_trig_high", trigger, 1);
    #2 rst = 1'b1;
    #1;
    chk("c6_trig_async", trigger, 0);
    step();
    rst = 1'b0;
    step();
    chk("c6_no_done", done, 0);
    chk("c6_no_abort", aborted, 0);

    // Normal command after reset: D=1 W=1 R=0
    issue(4, 1, 1, 0);
    chk("c7_wait", wait_reg, 4);
    chk("c7_trig_E", trigger, 0);
    step();
    chk("c7_trig_E+1", trigger, 1);
    step();
    chk("c7_trig_E+2", trigger, 0);
    chk("c7_done_E+2", done, 1);
    step();

    // Max delay/width: D=255 W=255 R=2, period 511
    issue(0, 255, 255, 2);
    run_train(2000, pulses, first_rise, last_rise, min_gap, max_gap, hi_cyc, end_k);
    chk("c8_pulses", pulses, 3);
    chk("c8_first_rise", first_rise, 255);
    chk("c8_min_period", min_gap, 511);
    chk("c8_max_period", max_gap, 511);
    chk("c8_hi_cycles", hi_cyc, 765);
    chk("c8_done_at", end_k, 1532);
    step();
    chk("c8_single_done", done, 0);

    // Max repeat: D=0 W=0 R=255 -> 256 pulses every 2 cycles
    issue(0, 0, 0, 255);
    run_train(1000, pulses, first_rise, last_rise, min_gap, max_gap, hi_cyc, end_k);
    chk("c9_pulses", pulses, 256);
    chk("c9_first_rise", first_rise, 0);
    chk("c9_min_period", min_gap, 2);
    chk("c9_max_period", max_gap, 2);
    chk("c9_hi_cycles", hi_cyc, 256);
    chk("c9_done_at", end_k, 511);
    step();
    chk("c9_single_done", done, 0);
    chk("c9_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
